vp_stream_switch: RTL
=====================

Name: vp_stream_switch

Overview:
- Parametrised successor to the fixed 8-way video output selector in the vp top level.
- Selects one of N_CH pipeline-stage video streams (de/h_sync/v_sync/pixel) under switch control and drives the registered output.
- Changes selection only at a frame boundary, so switching never produces tearing.
- Can blank pixel data for a programmable number of frames after each switch; sync and de timing keep running during blanking.

Parameters:
- N_CH, 8, number of input streams (2..16).
- SEL_W, 3, width of sel; must satisfy 2^SEL_W >= N_CH.
- PIX_W, 24, pixel width per stream.
- FRAME_SYNC, 1, 1 = switch only on a v_sync rising edge of the active stream; 0 = switch immediately.
- BLANK_FRAMES, 1, number of frames pixel_out is forced to 0 after a switch (0..15); 0 disables blanking.

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous reset, active-high
- sel  in  SEL_W  requested stream (asynchronous source, from slide switches)
- de_in  in  N_CH  data enable, bit i = stream i
- h_sync_in  in  N_CH  horizontal sync, bit i = stream i
- v_sync_in  in  N_CH  vertical sync, bit i = stream i, active-high
- pixel_in  in  N_CH*PIX_W  stream i at bits [i*PIX_W +: PIX_W]
- de_out  out  1  registered de of the active stream
- h_sync_out  out  1  registered h_sync of the active stream
- v_sync_out  out  1  registered v_sync of the active stream
- pixel_out  out  PIX_W  registered pixel of the active stream, or 0 while blanking
- active_sel  out  SEL_W  index of the stream currently driving the outputs
- switch_pending  out  1  high while a requested switch is waiting for a frame boundary

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; on reset every flop clears.
- Reset values:
  - de_out, h_sync_out, v_sync_out, pixel_out, switch_pending = 0.
  - active_sel = 0; state = RUN; blank counter = 0; synchroniser = 0.
- Sel synchroniser: sel passes through a 2-flop synchroniser to give sel_s.
  - Request latency: 2 cycles from a sel change to sel_s.
  - sel_s >= N_CH is invalid and treated as "no request" (equivalent to sel_s == active_sel).
- Data path: all outputs are registered, 1 cycle after the active stream's inputs.
  - de, h_sync and v_sync are always passed through, including during BLANK.
  - pixel_out = 0 while state == BLANK, otherwise the active stream's pixel.
- Frame edge: vs_prev holds the previous v_sync of the active stream.
  - vs_rise = v_sync_in[active_sel] & ~vs_prev.
  - When active_sel changes, vs_prev loads the new stream's current v_sync in the same cycle, so no spurious edge is seen.
- State machine, states RUN / WAIT_VS / BLANK:
  - RUN: if sel_s is a valid request different from active_sel:
    - FRAME_SYNC=1: go to WAIT_VS.
    - FRAME_SYNC=0: active_sel <= sel_s next cycle; go to BLANK if BLANK_FRAMES > 0, else stay in RUN.
  - WAIT_VS: switch_pending = 1 (registered, asserted the cycle after entry).
    - If sel_s returns to active_sel or becomes invalid: back to RUN, switch_pending = 0, no switch.
    - On vs_rise: active_sel <= latest sel_s (a request changed during the wait is honoured); then BLANK if BLANK_FRAMES > 0, else RUN.
    - The output v_sync rising edge of the old stream is emitted; the new stream drives the outputs from the following cycle.
  - BLANK: counter loaded with BLANK_FRAMES on entry; decremented on each vs_rise of the new stream; when it reaches 0 the FSM goes to RUN on that same edge cycle.
    - Requests arriving in BLANK are deferred and evaluated once RUN is reached.
- Simultaneous events: vs_rise in the same cycle a request first appears in RUN is not used; the switch waits for the next frame edge.
- Reset mid-operation: any state returns to RUN with active_sel = 0 on the next clk edge. A pending request is discarded, then re-evaluated from sel_s.
- Idle stream: if the active stream never toggles v_sync, WAIT_VS and BLANK hold indefinitely. No timeout.

Test Plan:
- Reset: rst=1 for 3 cycles with all inputs toggling -> all outputs 0, active_sel=0; 1 cycle after release, outputs track stream 0 with 1-cycle latency.
- Frame-synchronous switch (FRAME_SYNC=1, BLANK_FRAMES=1):
  - Stimulus: sel 0->3 mid-frame; stream 0 pixel=0x112233, stream 3 pixel=0xAABBCC.
  - Required: switch_pending=1 from cycle 3 to the stream-0 v_sync rise; then active_sel=3 and pixel_out=0 for one full frame with syncs running; then pixel_out=0xAABBCC.
- Cancel: sel 0->2 then back to 0 before a v_sync edge -> switch_pending drops, active_sel stays 0, pixel never blanks.
- Retarget: sel 0->2, then sel=5 before the edge -> at the edge active_sel=5, not 2.
- Invalid and immediate (N_CH=6, FRAME_SYNC=0, BLANK_FRAMES=0):
  - sel=7 -> no change.
  - sel=4 -> active_sel=4 three cycles after the sel change, no blanking, no glitch on v_sync_out.
- Reset in BLANK (BLANK_FRAMES=3): assert rst during the second blanked frame -> state RUN, active_sel=0, pixel_out follows stream 0 the cycle after release.

Source files
------------

// File: rtl/vp_stream_switch.sv
// Frame-synchronous N-way video stream selector with optional post-switch pixel blanking.
// All outputs are registered one cycle behind the selected stream's inputs.
module vp_stream_switch #(
   parameter int N_CH         = 8,
   parameter int SEL_W        = 3,
   parameter int PIX_W        = 24,
   parameter bit FRAME_SYNC   = 1'b1,
   parameter int BLANK_FRAMES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SEL_W-1:0]      sel,
   input  logic [N_CH-1:0]       de_in,
   input  logic [N_CH-1:0]       h_sync_in,
   input  logic [N_CH-1:0]       v_sync_in,
   input  logic [N_CH*PIX_W-1:0] pixel_in,
   output logic                  de_out,
   output logic                  h_sync_out,
   output logic                  v_sync_out,
   output logic [PIX_W-1:0]      pixel_out,
   output logic [SEL_W-1:0]      active_sel,
   output logic                  switch_pending
);

   typedef enum logic [1:0] {RUN, WAIT_VS, BLANK} state_t;

   localparam logic [3:0] BLANK_LOAD = 4'(BLANK_FRAMES);

   state_t           state;
   logic [SEL_W-1:0] sel_meta;
   logic [SEL_W-1:0] sel_s;
   logic [3:0]       blank_cnt;
   logic             vs_prev;

   logic             act_de;
   logic             act_hs;
   logic             act_vs;
   logic [PIX_W-1:0] act_pix;
   logic             req_vs;
   logic             req_valid;
   logic             vs_rise;

   // Stream muxes: the active stream feeds the outputs, the requested one seeds vs_prev on a switch.
   always_comb begin
      act_de  = 1'b0;
      act_hs  = 1'b0;
      act_vs  = 1'b0;
      act_pix = '0;
      req_vs  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (active_sel == SEL_W'(i)) begin
            act_de  = de_in[i];
            act_hs  = h_sync_in[i];
            act_vs  = v_sync_in[i];
            act_pix = pixel_in[i*PIX_W +: PIX_W];
         end
         if (sel_s == SEL_W'(i)) begin
            req_vs = v_sync_in[i];
         end
      end
   end

   assign req_valid = (int'(sel_s) < N_CH) && (sel_s != active_sel);
   assign vs_rise   = act_vs & ~vs_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_meta       <= '0;
         sel_s          <= '0;
         state          <= RUN;
         active_sel     <= '0;
         blank_cnt      <= '0;
         vs_prev        <= 1'b0;
         switch_pending <= 1'b0;
         de_out         <= 1'b0;
         h_sync_out     <= 1'b0;
         v_sync_out     <= 1'b0;
         pixel_out      <= '0;
      end else begin
         // NOTE: every flop here uses <= so each branch sees pre-edge values of active_sel and state.
         sel_meta   <= sel;
         sel_s      <= sel_meta;
         de_out     <= act_de;
         h_sync_out <= act_hs;
         v_sync_out <= act_vs;
         pixel_out  <= (state == BLANK) ? '0 : act_pix;
         vs_prev    <= act_vs;

         case (state)
            RUN: begin
               if (req_valid) begin
                  if (FRAME_SYNC) begin
                     state          <= WAIT_VS;
                     switch_pending <= 1'b1;
                  end else begin
                     active_sel <= sel_s;
                     vs_prev    <= req_vs;
                     if (BLANK_FRAMES > 0) begin
                        state     <= BLANK;
                        blank_cnt <= BLANK_LOAD;
                     end
                  end
               end
            end
            WAIT_VS: begin
               if (!req_valid) begin
                  state          <= RUN;
                  switch_pending <= 1'b0;
               end else if (vs_rise) begin
                  active_sel     <= sel_s;
                  vs_prev        <= req_vs;
                  switch_pending <= 1'b0;
                  if (BLANK_FRAMES > 0) begin
                     state     <= BLANK;
                     blank_cnt <= BLANK_LOAD;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            BLANK: begin
               if (vs_rise) begin
                  if (blank_cnt <= 4'd1) begin
                     blank_cnt <= '0;
                     state     <= RUN;
                  end else begin
                     blank_cnt <= blank_cnt - 4'd1;
                  end
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule
